// File: rtl/onebit_pkg.sv
// Shared defaults and FSM state type for the serial program loader.
// The parity build option is LOADER_PARITY_EN; see serial_prog_loader.sv.
package onebit_pkg;

    localparam int INSTR_W_DEF = 13;
    localparam int DEPTH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_PARITY = 2'd1,
        ST_FULL   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/loader_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-edge read and write to one address returns the old contents.
module loader_mem
    import onebit_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [INSTR_W-1:0]       i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [INSTR_W-1:0]       o_rdData
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdData;

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/serial_prog_loader.sv
// Serial instruction loader: shifts ser_in LSB-first into words and stores them.
// Define LOADER_PARITY_EN to expect a trailing even-parity bit per word.
module serial_prog_loader
    import onebit_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     ser_in,
    input  logic                     clear,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [INSTR_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     full,
    output logic                     word_valid,
    output logic                     parity_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (INSTR_W > 1) ? $clog2(INSTR_W) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(INSTR_W - 1);
    localparam logic [AW:0]   WC_LAST  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   WC_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);

    loader_state_t r_state;
    loader_state_t w_stateNext;

    logic [BW-1:0]      r_bitCnt;
    logic [INSTR_W-1:0] r_shift;
    logic [AW-1:0]      r_wrPtr;
    logic [AW:0]        r_wordCount;
    logic               r_wordValid;

    logic [INSTR_W-1:0] w_word;
    logic [INSTR_W-1:0] w_commitWord;
    logic               w_commit;
    logic               w_sample;
    logic               w_lastBit;
    logic               w_lastWord;

`ifdef LOADER_PARITY_EN
    logic               r_parityErr;
    logic               w_parityFail;
`endif

    assign w_sample   = en && (r_state == ST_SHIFT);
    assign w_lastBit  = (r_bitCnt == LAST_BIT);
    assign w_lastWord = (r_wordCount == WC_LAST);

    // Partial word with the incoming bit merged at its position.
    always_comb begin
        w_word           = r_shift;
        w_word[r_bitCnt] = ser_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SHIFT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_commit     = 1'b0;
        w_commitWord = w_word;
`ifdef LOADER_PARITY_EN
        w_parityFail = 1'b0;
`endif
        if (clear) begin
            w_stateNext = ST_SHIFT;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (en && w_lastBit) begin
`ifdef LOADER_PARITY_EN
                        w_stateNext = ST_PARITY;
`else
                        w_commit = 1'b1;
                        if (w_lastWord) begin
                            w_stateNext = ST_FULL;
                        end
`endif
                    end
                end
                ST_PARITY: begin
`ifdef LOADER_PARITY_EN
                    // The full word already sits in r_shift; only the parity bit arrives here.
                    if (en) begin
                        w_commitWord = r_shift;
                        w_stateNext  = ST_SHIFT;
                        if ((^{r_shift, ser_in}) == 1'b0) begin
                            w_commit = 1'b1;
                            if (w_lastWord) begin
                                w_stateNext = ST_FULL;
                            end
                        end else begin
                            w_parityFail = 1'b1;
                        end
                    end
`else
                    w_stateNext = ST_SHIFT;
`endif
                end
                ST_FULL:  w_stateNext = ST_FULL;
                default:  w_stateNext = ST_SHIFT;
            endcase
        end
    end

    // Datapath counters; clear restarts loading but leaves memory alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_wrPtr     <= '0;
            r_wordCount <= '0;
            r_wordValid <= 1'b0;
        end else if (clear) begin
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_wrPtr     <= '0;
            r_wordCount <= '0;
            r_wordValid <= 1'b0;
        end else begin
            r_wordValid <= w_commit;
            if (w_sample) begin
                r_shift  <= w_word;
                r_bitCnt <= w_lastBit ? '0 : r_bitCnt + 1'b1;
            end
            if (w_commit) begin
                r_wordCount <= r_wordCount + 1'b1;
                if (r_wrPtr != PTR_MAX) begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                end
            end
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_parityErr <= 1'b0;
        end else if (w_parityFail) begin
            r_parityErr <= 1'b1;
        end
    end

    assign parity_err = r_parityErr;
`else
    assign parity_err = 1'b0;
`endif

    loader_mem #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_we     (w_commit),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_commitWord),
        .i_rdAddr (rd_addr),
        .o_rdData (rd_data)
    );

    assign word_count = r_wordCount;
    assign full       = (r_wordCount == WC_FULL);
    assign word_valid = r_wordValid;

endmodule

// File: doc/serial_prog_loader.md
SERIAL_PROG_LOADER -- requirements
Module: serial_prog_loader

Interface
REQ-001 Parameter INSTR_W, default 13, instruction word width in bits (min 2).
REQ-002 Parameter DEPTH, default 8, number of instruction words stored (power of two, min 2); AW = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  load enable; ser_in is sampled on every rising edge with en=1.
REQ-006 ser_in  input  1  serial instruction bit stream.
REQ-007 clear  input  1  synchronous restart of loading at address 0; memory contents retained.
REQ-008 rd_addr  input  AW  fetch address from the processor core.
REQ-009 rd_data  output  INSTR_W  registered instruction word read from rd_addr.
REQ-010 word_count  output  AW+1  number of words committed since reset/clear.
REQ-011 full  output  1  high when word_count == DEPTH.
REQ-012 word_valid  output  1  one-cycle pulse, the cycle after a word commits.
REQ-013 parity_err  output  1  sticky parity-failure flag (LOADER_PARITY_EN only).

Function
REQ-014 FSM states: SHIFT (collecting data bits), PARITY (awaiting parity bit, LOADER_PARITY_EN only), FULL.
REQ-015 In SHIFT with en=1, ser_in is stored at bit index bit_cnt (first bit received -> bit 0) and bit_cnt increments.
REQ-016 en=0 holds bit_cnt, the partial word and the state unchanged (loading pauses mid-word with no loss).
REQ-017 On the edge sampling bit INSTR_W-1 (no parity): the full word, including that bit, is written to mem[wr_ptr], wr_ptr and word_count increment, and bit_cnt returns to 0.
REQ-018 word_valid is high for exactly the one cycle following each commit.
REQ-019 When word_count reaches DEPTH: FSM enters FULL, full=1, en and ser_in are ignored, wr_ptr does not wrap.
REQ-020 Only clear or reset leaves FULL.
REQ-021 rd_data = mem[rd_addr] registered, 1-cycle latency; a same-edge read and write to one address returns the old data.
REQ-022 clear=1: bit_cnt, wr_ptr, word_count, full and parity_err go to 0 and the FSM goes to SHIFT; memory is untouched.
REQ-023 clear takes priority over a simultaneous en; the bit sampled that cycle is discarded.
REQ-024 clear mid-word discards the partial word.

Reset
REQ-025 reset has priority over clear and en.
REQ-026 On reset: state=SHIFT, bit_cnt=0, wr_ptr=0, word_count=0, full=0, word_valid=0, parity_err=0, rd_data=0.
REQ-027 Memory array is not reset; contents are undefined until written.

Configuration
REQ-028 Macro LOADER_PARITY_EN: when defined, each word is followed by one extra even-parity bit (XOR of data plus parity = 0), received in state PARITY.
REQ-029 With LOADER_PARITY_EN and correct parity: commit on the parity-bit edge per REQ-017/018.
REQ-030 With LOADER_PARITY_EN and a parity mismatch: the word is discarded, wr_ptr and word_count are unchanged, parity_err is set to 1 (sticky), and the FSM returns to SHIFT.
REQ-031 Without LOADER_PARITY_EN: there is no PARITY state, the port is present and parity_err is tied 0.

Structure
REQ-032 Shared package onebit_pkg holds the INSTR_W/DEPTH defaults and the loader FSM state typedef.
REQ-033 Sub-module loader_mem: a simple dual-port synchronous RAM (one write port, one registered read port), parametrised by INSTR_W and DEPTH.

Verification
REQ-034 Scenario: 13 cycles of ser_in=1 with en=1 -> mem[0]=0x1FFF, word_count=1, word_valid pulse once; rd_addr=0 gives rd_data=0x1FFF one cycle later.
REQ-035 Scenario: alternating ser_in starting 1, then alternating starting 0 -> mem[0]=0x1555, mem[1]=0x0AAA, word_count=2.
REQ-036 Scenario: 8 full words then 13 more bits -> full=1 after the 8th commit, word_count=8, mem[0..7] unchanged by the extra bits.
REQ-037 Scenario: en dropped for 5 cycles after bit 6 of a word, then resumed -> committed word is identical to the uninterrupted case.
REQ-038 Scenario: clear asserted after bit 4, then 13 ones -> mem[0]=0x1FFF, word_count=1, full=0.
REQ-039 Scenario (LOADER_PARITY_EN): word 0x0001 with parity bit 0 -> not committed, parity_err=1, word_count=0; the same word with parity bit 1 -> committed, word_count=1.
